// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic LINE_IDLE      = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bit_tick = !restart && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead byte FIFO into 8N1/8N2 UART frames, LSB first.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1)
    begin : g_bad_cfg
        $error("fifo_uart_tx: illegal CLKS_PER_BIT, STOP_BITS or PARITY_ODD");
    end

    uart_state_t state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        tx_d, busy_d, rd_d, done_d;
    logic        restart, bit_tick, start_ok;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (restart),
        .bit_tick (bit_tick)
    );

    assign start_ok = en && !fifo_empty;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx;
        busy_d    = busy;
        rd_d      = 1'b0;
        done_d    = 1'b0;
        restart   = 1'b0;
        case (state_q)
            IDLE: begin
                // Hold the divider at zero so the start bit gets a full bit time.
                restart = 1'b1;
                tx_d    = LINE_IDLE;
                busy_d  = 1'b0;
                if (start_ok) begin
                    state_d = START;
                    data_d  = fifo_data;
                    rd_d    = 1'b1;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_d      = data_q[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = (^data_q) ^ PARITY_ODD[0];
`else
                        state_d   = STOP;
                        bit_cnt_d = '0;
                        tx_d      = LINE_IDLE;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = data_q[bit_cnt_d];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                    tx_d      = LINE_IDLE;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        done_d = 1'b1;
                        // Back-to-back: next start bit follows the stop bit with no gap.
                        if (start_ok) begin
                            state_d = START;
                            data_d  = fifo_data;
                            rd_d    = 1'b1;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = LINE_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            bit_cnt_q <= '0;
            tx        <= LINE_IDLE;
            busy      <= 1'b0;
            fifo_rd   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            bit_cnt_q <= bit_cnt_d;
            tx        <= tx_d;
            busy      <= busy_d;
            fifo_rd   <= rd_d;
            tx_done   <= done_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, frame-timeline reference model, directed and random stimulus.
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int STOPB = 1;
    localparam int PODD  = 0;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 10 + STOPB;
    localparam int LIT_FRAME_CLKS = 44;
    localparam logic [11:0] LIT_A5_BITS = 12'h54A;
`else
    localparam int FRAME_BITS = 9 + STOPB;
    localparam int LIT_FRAME_CLKS = 40;
    localparam logic [11:0] LIT_A5_BITS = 12'h34A;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd, tx, busy, tx_done;

    logic [7:0] q[$];
    int checks = 0;
    int errors = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(STOPB), .PARITY_ODD(PODD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic refresh();
        fifo_empty = (q.size() == 0);
        fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] frame_of(input logic [7:0] d);
        logic [11:0] b;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = d;
`ifdef UART_TX_PARITY_EN
        b[9]   = (^d) ^ PODD[0];
`endif
        return b;
    endfunction

    // Reference model: a frame is a fixed bit vector played out over FRAME_CLKS cycles.
    logic        m_active = 1'b0;
    int          m_elapsed = 0;
    logic [11:0] m_bits = '1;
    logic        e_tx = 1'b1, e_busy = 1'b0, e_rd = 1'b0, e_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0; m_elapsed = 0;
            e_tx = 1'b1; e_busy = 1'b0; e_rd = 1'b0; e_done = 1'b0;
        end else begin
            e_rd = 1'b0; e_done = 1'b0;
            if (m_active) begin
                m_elapsed++;
                if (m_elapsed == FRAME_CLKS) begin
                    m_active = 1'b0;
                    e_done   = 1'b1;
                end
            end
            if (!m_active && en && !fifo_empty) begin
                m_active  = 1'b1;
                m_elapsed = 0;
                m_bits    = frame_of(fifo_data);
                e_rd      = 1'b1;
            end
            e_tx   = m_active ? m_bits[m_elapsed / CPB] : 1'b1;
            e_busy = m_active;
        end
    end

    // Compare process plus FIFO pop and event logging.
    int   cyc = 0;
    int   pops = 0, dones = 0;
    int   rd_log[$];
    int   done_log[$];
    logic txlog [0:16383];

    always @(negedge clk) begin
        cyc++;
        txlog[cyc & 16383] = tx;
        check("tx", {31'b0, tx}, {31'b0, e_tx});
        check("busy", {31'b0, busy}, {31'b0, e_busy});
        check("fifo_rd", {31'b0, fifo_rd}, {31'b0, e_rd});
        check("tx_done", {31'b0, tx_done}, {31'b0, e_done});
        if (fifo_rd === 1'b1) begin
            pops++;
            rd_log.push_back(cyc);
            if (q.size() > 0) void'(q.pop_front());
            refresh();
        end
        if (tx_done === 1'b1) begin
            dones++;
            done_log.push_back(cyc);
        end
    end

    task automatic wait_dones(input int n, input int bound, input string name);
        int k = 0;
        while (dones < n && k < bound) begin
            @(negedge clk); #1;
            k++;
        end
        if (dones < n) check(name, dones, n);
    endtask

    task automatic wait_pops(input int n, input int bound, input string name);
        int k = 0;
        while (pops < n && k < bound) begin
            @(negedge clk); #1;
            k++;
        end
        if (pops < n) check(name, pops, n);
    endtask

    task automatic at_drive();
        @(posedge clk); #2;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    initial begin
        int p0, d0, rc;
        logic [11:0] got;

        // reset without a clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx", {31'b0, tx}, 1);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_rd", {31'b0, fifo_rd}, 0);
        check("rst_done", {31'b0, tx_done}, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        refresh();

        // single byte 0xA5
        at_drive();
        q.push_back(8'hA5); refresh(); en = 1'b1;
        wait_dones(1, 200, "a5_timeout");
        idle_cycles(5);
        check("a5_pops", pops, 1);
        rc = rd_log[0];
        check("a5_done_latency", done_log[0] - rc, LIT_FRAME_CLKS);
        got = '0;
        for (int i = 0; i < FRAME_BITS; i++) got[i] = txlog[(rc + i * CPB + 2) & 16383];
        check("a5_bits", {20'b0, got}, {20'b0, LIT_A5_BITS});

        // three queued bytes, back-to-back
        p0 = pops; d0 = dones;
        at_drive();
        q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h55); refresh();
        wait_dones(d0 + 3, 600, "burst_timeout");
        idle_cycles(30);
        check("burst_pops", pops - p0, 3);
        check("burst_dones", dones - d0, 3);
        check("burst_fifo_left", q.size(), 0);
        check("burst_gap01", rd_log[p0 + 1] - rd_log[p0], LIT_FRAME_CLKS);
        check("burst_gap12", rd_log[p0 + 2] - rd_log[p0 + 1], LIT_FRAME_CLKS);

        // en low holds off pops; dropping en mid-frame finishes the frame only
        at_drive();
        en = 1'b0; q.push_back(8'h81); refresh();
        p0 = pops;
        idle_cycles(50);
        check("en0_pops", pops - p0, 0);
        check("en0_tx", {31'b0, tx}, 1);
        at_drive();
        q.push_back(8'h42); refresh(); en = 1'b1;
        wait_pops(p0 + 1, 10, "en1_pop_timeout");
        d0 = dones;
        repeat (10) @(posedge clk);
        #2 en = 1'b0;
        wait_dones(d0 + 1, 100, "endrop_timeout");
        idle_cycles(60);
        check("endrop_pops", pops - p0, 1);
        check("endrop_fifo_left", q.size(), 1);
        at_drive();
        q.delete(); refresh();

        // reset in the middle of frame 0x3C
        at_drive();
        q.push_back(8'h3C); refresh(); en = 1'b1;
        wait_pops(pops + 1, 10, "r3c_pop_timeout");
        repeat (17) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx", {31'b0, tx}, 1);
        check("midrst_busy", {31'b0, busy}, 0);
        check("midrst_rd", {31'b0, fifo_rd}, 0);
        check("midrst_done", {31'b0, tx_done}, 0);
        check("midrst_fifo", q.size(), 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        p0 = pops;
        idle_cycles(50);
        check("postrst_pops", pops - p0, 0);
        check("postrst_tx", {31'b0, tx}, 1);

        // randomized traffic, model checks every cycle
        for (int c = 0; c < 2500; c++) begin
            at_drive();
            if ($urandom_range(7) == 0 && q.size() < 6) begin
                q.push_back(8'($urandom));
                refresh();
            end
            if ($urandom_range(63) == 0) en = ~en;
        end
        at_drive();
        en = 1'b1;
        begin
            int k = 0;
            while ((q.size() != 0 || busy !== 1'b0) && k < 1000) begin
                @(negedge clk); #1;
                k++;
            end
        end
        idle_cycles(5);
        check("drain_fifo", q.size(), 0);
        check("drain_busy", {31'b0, busy}, 0);
        check("pops_vs_frames", pops - dones, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
